// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Tracks in-flight destinations, drives forwarding, load-use stall, flush and halt drain.
module hazard_ctrl #(
    parameter  int STAGES     = 3,
    parameter  int REG_WORDS  = 32,
    parameter  int LOAD_STAGE = 2,
    localparam int RA         = $clog2(REG_WORDS),
    localparam int FWD_W      = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             id_valid,
    input  logic [RA-1:0]    id_r1_addr,
    input  logic [RA-1:0]    id_r2_addr,
    input  logic             id_r1_used,
    input  logic             id_r2_used,
    input  logic             id_rw_,
    input  logic [RA-1:0]    id_waddr,
    input  logic             id_sel_mem,
    input  logic             id_halt,
    input  logic             branch_taken,
    output logic [FWD_W-1:0] fwd_sel_1,
    output logic [FWD_W-1:0] fwd_sel_2,
    output logic             stall,
    output logic             flush,
    output logic             halt,
    output logic [FWD_W-1:0] inflight,
    output logic [15:0]      stall_cycles
);

    logic [STAGES:1]  r_vld;
    logic [STAGES:1]  r_wr;
    logic [STAGES:1]  r_ld;
    logic [STAGES:1]  r_hlt;
    logic [RA-1:0]    r_waddr [1:STAGES];
    logic             r_hpend;
    logic             r_halt;
    logic [15:0]      r_scnt;

    logic [FWD_W-1:0] w_sel1;
    logic [FWD_W-1:0] w_sel2;
    logic             w_lu1;
    logic             w_lu2;
    logic             w_flush;
    logic             w_stall;
    logic             w_acc;
    logic             w_s1_vld;
    logic             w_s1_wr;
    logic             w_s1_ld;
    logic             w_s1_hlt;
    logic [RA-1:0]    w_s1_waddr;

    // Youngest matching producer per operand; flag loads whose data is not ready yet
    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        w_lu1  = 1'b0;
        w_lu2  = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (r_vld[k] && r_wr[k] && (r_waddr[k] == id_r1_addr)) begin
                w_sel1 = FWD_W'(k);
                w_lu1  = r_ld[k] && (k < LOAD_STAGE);
            end
            if (r_vld[k] && r_wr[k] && (r_waddr[k] == id_r2_addr)) begin
                w_sel2 = FWD_W'(k);
                w_lu2  = r_ld[k] && (k < LOAD_STAGE);
            end
        end
        if (!id_r1_used || (id_r1_addr == '0)) begin
            w_sel1 = '0;
            w_lu1  = 1'b0;
        end
        if (!id_r2_used || (id_r2_addr == '0)) begin
            w_sel2 = '0;
            w_lu2  = 1'b0;
        end
    end

    // Flush beats stall; a draining pipeline never stalls; stage-1 entry or bubble
    always_comb begin
        w_flush    = branch_taken;
        w_stall    = id_valid & ~w_flush & ~r_hpend & (w_lu1 | w_lu2);
        w_acc      = ~w_flush & ~w_stall & ~r_hpend;
        w_s1_vld   = w_acc & id_valid;
        w_s1_wr    = w_acc & ~id_rw_ & (id_waddr != '0);
        w_s1_ld    = w_acc & id_sel_mem;
        w_s1_hlt   = w_acc & id_halt;
        w_s1_waddr = w_acc ? id_waddr : '0;
    end

    // Shift the tracking pipeline, latch sticky halt state, count stalled cycles
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_vld   <= '0;
            r_wr    <= '0;
            r_ld    <= '0;
            r_hlt   <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                r_waddr[k] <= '0;
            end
            r_hpend <= 1'b0;
            r_halt  <= 1'b0;
            r_scnt  <= '0;
        end else begin
            r_vld      <= {r_vld[STAGES-1:1], w_s1_vld};
            r_wr       <= {r_wr[STAGES-1:1], w_s1_wr};
            r_ld       <= {r_ld[STAGES-1:1], w_s1_ld};
            r_hlt      <= {r_hlt[STAGES-1:1], w_s1_hlt};
            r_waddr[1] <= w_s1_waddr;
            for (int k = 2; k <= STAGES; k++) begin
                r_waddr[k] <= r_waddr[k-1];
            end
            r_hpend <= r_hpend | w_s1_hlt;
            r_halt  <= r_halt | r_hlt[STAGES];
            if (w_stall && (r_scnt != 16'hFFFF)) begin
                r_scnt <= r_scnt + 16'd1;
            end
        end
    end

    assign fwd_sel_1    = w_sel1;
    assign fwd_sel_2    = w_sel2;
    assign stall        = w_stall;
    assign flush        = w_flush;
    assign halt         = r_halt;
    assign inflight     = FWD_W'($countones(r_vld));
    assign stall_cycles = r_scnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl.
// Default instance covers hazards and halt; a deep instance covers counter saturation.
module tb_hazard_ctrl;

    localparam int RA = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_;
    logic          id_valid;
    logic [RA-1:0] id_r1_addr;
    logic [RA-1:0] id_r2_addr;
    logic          id_r1_used;
    logic          id_r2_used;
    logic          id_rw_;
    logic [RA-1:0] id_waddr;
    logic          id_sel_mem;
    logic          id_halt;
    logic          branch_taken;
    logic [1:0]    fwd_sel_1;
    logic [1:0]    fwd_sel_2;
    logic          stall;
    logic          flush;
    logic          halt;
    logic [1:0]    inflight;
    logic [15:0]   stall_cycles;

    logic          s_rst_;
    logic [2:0]    s_fwd1;
    logic [2:0]    s_fwd2;
    logic          s_stall;
    logic          s_flush;
    logic          s_halt;
    logic [2:0]    s_infl;
    logic [15:0]   s_cnt;

    hazard_ctrl u_dut (
        .clk(clk), .rst_(rst_), .id_valid(id_valid),
        .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .id_rw_(id_rw_), .id_waddr(id_waddr), .id_sel_mem(id_sel_mem),
        .id_halt(id_halt), .branch_taken(branch_taken),
        .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2), .stall(stall),
        .flush(flush), .halt(halt), .inflight(inflight),
        .stall_cycles(stall_cycles)
    );

    // lw r5, 0(r5) issued back to back: stalls 6 of every 7 cycles
    hazard_ctrl #(.STAGES(7), .LOAD_STAGE(7)) u_sat (
        .clk(clk), .rst_(s_rst_), .id_valid(1'b1),
        .id_r1_addr(5'd5), .id_r2_addr(5'd0),
        .id_r1_used(1'b1), .id_r2_used(1'b0),
        .id_rw_(1'b0), .id_waddr(5'd5), .id_sel_mem(1'b1),
        .id_halt(1'b0), .branch_taken(1'b0),
        .fwd_sel_1(s_fwd1), .fwd_sel_2(s_fwd2), .stall(s_stall),
        .flush(s_flush), .halt(s_halt), .inflight(s_infl),
        .stall_cycles(s_cnt)
    );

    typedef struct {
        int f1;
        int f2;
        int st;
        int fl;
        int inf;
        int h;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   sat_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(int f1, int f2, int st, int fl,
                                int inf, int h, int cnt);
        exp_t e;
        e.f1 = f1; e.f2 = f2; e.st = st; e.fl = fl;
        e.inf = inf; e.h = h; e.cnt = cnt;
        return e;
    endfunction

    task automatic pop_cmp(string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".fwd1"},  32'(fwd_sel_1),    e.f1);
        chk({tag, ".fwd2"},  32'(fwd_sel_2),    e.f2);
        chk({tag, ".stall"}, 32'(stall),        e.st);
        chk({tag, ".flush"}, 32'(flush),        e.fl);
        chk({tag, ".infl"},  32'(inflight),     e.inf);
        chk({tag, ".halt"},  32'(halt),         e.h);
        chk({tag, ".scnt"},  32'(stall_cycles), e.cnt);
    endtask

    task automatic drv(bit v, int r1, bit u1, int r2, bit u2,
                       bit w, int wa, bit ld, bit h, bit br);
        id_valid     = v;
        id_r1_addr   = RA'(r1);
        id_r1_used   = u1;
        id_r2_addr   = RA'(r2);
        id_r2_used   = u2;
        id_rw_       = ~w;
        id_waddr     = RA'(wa);
        id_sel_mem   = ld;
        id_halt      = h;
        branch_taken = br;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // push expectation, compare mid-cycle, advance past the next edge
    task automatic cyc(string tag, exp_t e);
        sb.push_back(e);
        @(negedge clk);
        pop_cmp(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic sat_cmp(string tag, int e);
        sat_q.push_back(e);
        @(negedge clk);
        chk(tag, 32'(s_cnt), sat_q.pop_front());
    endtask

    initial begin
        rst_   = 1'b0;
        s_rst_ = 1'b0;
        nop();
        branch_taken = 1'b1;
        #3;
        sb.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        pop_cmp("reset");
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        rst_ = 1'b1;

        // ALU chain on r3
        drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); cyc("alu0", mk(0, 0, 0, 0, 0, 0, 0));
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cyc("alu1", mk(1, 0, 0, 0, 1, 0, 0));
        cyc("alu2", mk(2, 0, 0, 0, 2, 0, 0));
        cyc("alu3", mk(3, 0, 0, 0, 3, 0, 0));
        cyc("alu4", mk(0, 0, 0, 0, 3, 0, 0));
        nop();
        cyc("dr0a", mk(0, 0, 0, 0, 3, 0, 0));
        cyc("dr0b", mk(0, 0, 0, 0, 2, 0, 0));
        cyc("dr0c", mk(0, 0, 0, 0, 1, 0, 0));

        // load-use
        drv(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cyc("lu0", mk(0, 0, 0, 0, 0, 0, 0));
        drv(1, 5, 1, 2, 1, 1, 6, 0, 0, 0); cyc("lu1", mk(1, 0, 1, 0, 1, 0, 0));
        cyc("lu2", mk(2, 0, 0, 0, 1, 0, 1));
        nop();
        cyc("dr1a", mk(0, 0, 0, 0, 2, 0, 1));
        cyc("dr1b", mk(0, 0, 0, 0, 1, 0, 1));
        cyc("dr1c", mk(0, 0, 0, 0, 1, 0, 1));

        // multiple producers of r4, and r0
        drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); cyc("mp0", mk(0, 0, 0, 0, 0, 0, 1));
        nop();                             cyc("mp1", mk(0, 0, 0, 0, 1, 0, 1));
        drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); cyc("mp2", mk(0, 0, 0, 0, 1, 0, 1));
        drv(1, 4, 1, 4, 1, 0, 0, 0, 0, 0); cyc("mp3", mk(1, 1, 0, 0, 2, 0, 1));
        drv(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); cyc("mp4", mk(0, 0, 0, 0, 2, 0, 1));
        drv(1, 0, 1, 4, 1, 0, 0, 0, 0, 0); cyc("mp5", mk(0, 3, 0, 0, 3, 0, 1));
        nop();
        cyc("dr2a", mk(0, 0, 0, 0, 3, 0, 1));
        cyc("dr2b", mk(0, 0, 0, 0, 2, 0, 1));
        cyc("dr2c", mk(0, 0, 0, 0, 1, 0, 1));

        // flush versus stall
        drv(1, 0, 0, 0, 0, 1, 7, 1, 0, 0); cyc("fs0", mk(0, 0, 0, 0, 0, 0, 1));
        drv(1, 7, 1, 0, 0, 1, 8, 0, 0, 1); cyc("fs1", mk(1, 0, 0, 1, 1, 0, 1));
        drv(1, 8, 1, 7, 1, 0, 0, 0, 0, 0); cyc("fs2", mk(0, 2, 0, 0, 1, 0, 1));
        nop();
        cyc("dr3a", mk(0, 0, 0, 0, 2, 0, 1));
        cyc("dr3b", mk(0, 0, 0, 0, 1, 0, 1));
        cyc("dr3c", mk(0, 0, 0, 0, 1, 0, 1));

        // halt drain with decode kept busy
        drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("hl0", mk(0, 0, 0, 0, 0, 0, 1));
        drv(1, 0, 0, 0, 0, 1, 9, 1, 0, 0); cyc("hl1", mk(0, 0, 0, 0, 1, 0, 1));
        drv(1, 9, 1, 9, 1, 1, 9, 1, 0, 0); cyc("hl2", mk(0, 0, 0, 0, 1, 0, 1));
        cyc("hl3", mk(0, 0, 0, 0, 1, 0, 1));
        cyc("hl4", mk(0, 0, 0, 0, 0, 1, 1));
        cyc("hl5", mk(0, 0, 0, 0, 0, 1, 1));

        // reset clears sticky halt
        nop();
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        rst_ = 1'b0;
        #2;
        pop_cmp("hrst");
        @(posedge clk);
        #1;
        rst_ = 1'b1;

        // seven load-use stalls
        for (int i = 0; i < 7; i++) begin
            drv(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
            cyc("bldA", mk(0, 0, 0, 0, (i == 0) ? 0 : 2, 0, i));
            drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
            cyc("bldB", mk(1, 0, 1, 0, (i == 0) ? 1 : 2, 0, i));
            cyc("bldC", mk(2, 0, 0, 0, (i == 0) ? 1 : 2, 0, i + 1));
        end
        drv(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
        cyc("fillD", mk(0, 0, 0, 0, 2, 0, 7));
        cyc("fillE", mk(0, 0, 0, 0, 2, 0, 7));
        cyc("fillF", mk(0, 0, 0, 0, 3, 0, 7));

        // reset mid-cycle with three valid entries
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        rst_ = 1'b0;
        #2;
        pop_cmp("midrst");
        nop();
        @(posedge clk);
        #1;
        rst_ = 1'b1;

        // saturation on the deep instance
        s_rst_ = 1'b1;
        repeat (7) @(posedge clk);
        sat_cmp("sat7", 6);
        repeat (77000) @(posedge clk);
        sat_cmp("satmax", 16'hFFFF);
        repeat (7) @(posedge clk);
        sat_cmp("sathold", 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
